// File: rtl/qmult_arb.sv
// qmult_arb: round-robin arbiter and pipeline controller that lets R lanes
// share one qmult fixed-point multiplier. Each lane offers an operand pair
// with valid/ready. At most one pair is granted per cycle. The registered
// product comes back tagged with the index of the lane that issued it.
//
// Build option: define QMULT_ARB_PIPE_EN to insert a stage-1 register
// {a, b, id, valid} between the arbiter and the multiplier. This gives a
// latency of 2 cycles. When the macro is undefined, the latency is 1 cycle.
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   rst_n      - asynchronous active-low reset
//   req_valid  - [R]   lane i has an operand pair
//   req_ready  - [R]   lane i's pair is taken this cycle
//   req_a      - [R*N] operand a, lane i at [i*N +: N]
//   req_b      - [R*N] operand b, packed like req_a
//   rsp_valid  - result register holds a product
//   rsp_ready  - consumer takes the product
//   rsp_result - [N]   product (qmult sign-magnitude format)
//   rsp_id     - [IW]  index of the lane that issued the product

// qmult: sign is the XOR of the operand signs. The magnitude is the middle
// slice of the raw magnitude product. Truncation only, with no saturation.
module qmult #(
  parameter int N = 16,
  parameter int Q = 10
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result
);
  localparam int PW = 2 * (N - 1);

  logic [PW-1:0] mag_product;
  logic          unused_product_bits;

  assign mag_product = {{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, b[N-2:0]};
  assign result      = {a[N-1] ^ b[N-1], mag_product[N-2+Q:Q]};

  // Truncated bits are dropped on purpose.
  assign unused_product_bits = ^{mag_product[PW-1:N-1+Q], mag_product[Q-1:0]};
endmodule

module qmult_arb #(
  parameter  int N  = 16,
  parameter  int Q  = 10,
  parameter  int R  = 4,
  localparam int IW = $clog2(R)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [R-1:0]    req_valid,
  output logic [R-1:0]    req_ready,
  input  logic [R*N-1:0]  req_a,
  input  logic [R*N-1:0]  req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [N-1:0]    rsp_result,
  output logic [IW-1:0]   rsp_id
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_next;
  logic [R-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          grant_any;
  logic          accept;
  logic [N-1:0]  a_sel;
  logic [N-1:0]  b_sel;
  logic [N-1:0]  mult_a;
  logic [N-1:0]  mult_b;
  logic [N-1:0]  mult_result;

  // Search the lanes starting at ptr and wrap around past R-1.
  // The first valid lane in that order wins.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < R; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(R)) sum = sum - (IW+1)'(R);
      idx = sum[IW-1:0];
      if (!grant_any && req_valid[idx]) begin
        grant_any     = 1'b1;
        grant[idx]    = 1'b1;
        grant_id      = idx;
      end
    end
  end

  // Steer the winning lane's operands toward the multiplier.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < R; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*N +: N];
        b_sel = req_b[i*N +: N];
      end
    end
  end

  assign ptr_next  = (grant_id == IW'(R - 1)) ? '0 : grant_id + 1'b1;
  assign req_ready = rst_n ? (grant & {R{accept}}) : '0;

  // The priority pointer moves past the winner only when a pair is actually
  // taken, so lanes that are stalled do not lose their turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept && grant_any) begin
      ptr <= ptr_next;
    end
  end

  qmult #(.N(N), .Q(Q)) u_qmult (
    .a      (mult_a),
    .b      (mult_b),
    .result (mult_result)
  );

`ifdef QMULT_ARB_PIPE_EN
  logic [N-1:0]  s1_a;
  logic [N-1:0]  s1_b;
  logic [IW-1:0] s1_id;
  logic          s1_valid;
  logic          s1_advance;

  assign s1_advance = ~rsp_valid | rsp_ready;
  assign accept     = ~s1_valid | s1_advance;
  assign mult_a     = s1_a;
  assign mult_b     = s1_b;

  // Stage 1 captures the granted pair. It refills in the same cycle that
  // its contents move on, so a stall stops everything with no data lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (accept) begin
      s1_valid <= grant_any;
      if (grant_any) begin
        s1_a  <= a_sel;
        s1_b  <= b_sel;
        s1_id <= grant_id;
      end
    end
  end

  // The output register takes the product of whatever stage 1 holds.
  // An empty stage 1 leaves a bubble, but the old data is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= '0;
    end else if (s1_advance) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_result <= mult_result;
        rsp_id     <= s1_id;
      end
    end
  end
`else
  assign accept = ~rsp_valid | rsp_ready;
  assign mult_a = a_sel;
  assign mult_b = b_sel;

  // The product of the granted pair is registered directly. When the
  // consumer drains the register and a new grant arrives in the same cycle,
  // the register is overwritten with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= '0;
    end else if (accept) begin
      rsp_valid <= grant_any;
      if (grant_any) begin
        rsp_result <= mult_result;
        rsp_id     <= grant_id;
      end
    end
  end
`endif

endmodule
